// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the 8N1 UART: FSM state encodings, default clocking
// constants and the data-bit count.
package uart_pkg;
    localparam int DEF_CLK_FREQ = 50_000_000;
    localparam int DEF_BAUD     = 115_200;
    localparam int DATA_BITS    = 8;
    localparam int BIT_IDX_W    = $clog2(DATA_BITS);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM, data/ready outputs.
// Optional frame_err output when UART_FRAME_ERR_EN is defined.
module uart_rx import uart_pkg::*; #(
    parameter int CLKS_PER_BIT = DEF_CLK_FREQ / DEF_BAUD
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_data_ready
`ifdef UART_FRAME_ERR_EN
    ,
    output logic                 o_frame_err
`endif
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]     FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]     HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT  = BIT_IDX_W'(DATA_BITS - 1);

    rx_state_t              r_state, w_state_n;
    logic [CNT_W-1:0]       r_cnt, w_cnt_n;
    logic [BIT_IDX_W-1:0]   r_bit, w_bit_n;
    logic [DATA_BITS-1:0]   r_shift, w_shift_n;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_data_ready;
    logic                   r_rx_meta, r_rx_sync;
    logic                   w_stop_sample;
    logic                   w_load;

    // The stop bit is sampled mid-bit; returning to IDLE here leaves half a
    // bit of margin to catch the next start edge.
    assign w_stop_sample = (r_state == RX_STOP) && (r_cnt == FULL_LAST);
    assign w_load        = w_stop_sample && r_rx_sync;

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_bit_n   = r_bit;
        w_shift_n = r_shift;
        unique case (r_state)
            RX_IDLE: begin
                w_cnt_n = '0;
                w_bit_n = '0;
                if (!r_rx_sync) w_state_n = RX_START;
            end
            RX_START: begin
                if (r_cnt == HALF_LAST) begin
                    w_cnt_n   = '0;
                    w_state_n = r_rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (r_cnt == FULL_LAST) begin
                    w_cnt_n   = '0;
                    w_shift_n = {r_rx_sync, r_shift[DATA_BITS-1:1]};
                    if (r_bit == LAST_BIT) w_state_n = RX_STOP;
                    else                   w_bit_n   = r_bit + BIT_IDX_W'(1);
                end else begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (w_stop_sample) begin
                    w_cnt_n   = '0;
                    w_state_n = RX_IDLE;
                end else begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_meta    <= 1'b1;
            r_rx_sync    <= 1'b1;
            r_state      <= RX_IDLE;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_data       <= '0;
            r_data_ready <= 1'b0;
        end else begin
            r_rx_meta    <= i_rx;
            r_rx_sync    <= r_rx_meta;
            r_state      <= w_state_n;
            r_cnt        <= w_cnt_n;
            r_bit        <= w_bit_n;
            r_shift      <= w_shift_n;
            r_data_ready <= w_load;
            if (w_load) r_data <= r_shift;
        end
    end

    assign o_data       = r_data;
    assign o_data_ready = r_data_ready;

`ifdef UART_FRAME_ERR_EN
    logic r_frame_err;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_frame_err <= 1'b0;
        else       r_frame_err <= w_stop_sample && !r_rx_sync;
    end

    assign o_frame_err = r_frame_err;
`endif
endmodule

// File: rtl/uart_top.sv
`timescale 1ns/1ps
// Full-duplex 8N1 UART top: transmitter FSM plus the uart_rx receiver.
// Define UART_FRAME_ERR_EN to add the frame_err output.
module uart_top import uart_pkg::*; #(
    parameter int CLK_FREQ = DEF_CLK_FREQ,
    parameter int BAUD     = DEF_BAUD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 tx,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 send,
    output logic                 busy,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_ready
`ifdef UART_FRAME_ERR_EN
    ,
    output logic                 frame_err
`endif
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]     FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT  = BIT_IDX_W'(DATA_BITS - 1);

    tx_state_t            r_tx_state, w_tx_state_n;
    logic [CNT_W-1:0]     r_tx_cnt, w_tx_cnt_n;
    logic [BIT_IDX_W-1:0] r_tx_bit, w_tx_bit_n;
    logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_n;
    logic                 r_tx, w_tx_n;

    // Host handshake: send is a one-cycle request that is accepted only while
    // busy=0; a request seen while busy=1 is dropped, never queued. busy rises
    // the cycle after acceptance and falls when the stop bit completes.
    always_comb begin
        w_tx_state_n = r_tx_state;
        w_tx_cnt_n   = r_tx_cnt;
        w_tx_bit_n   = r_tx_bit;
        w_tx_shift_n = r_tx_shift;
        unique case (r_tx_state)
            TX_IDLE: begin
                w_tx_cnt_n = '0;
                w_tx_bit_n = '0;
                if (send) begin
                    w_tx_shift_n = data_in;
                    w_tx_state_n = TX_START;
                end
            end
            TX_START: begin
                if (r_tx_cnt == FULL_LAST) begin
                    w_tx_cnt_n   = '0;
                    w_tx_state_n = TX_DATA;
                end else begin
                    w_tx_cnt_n = r_tx_cnt + CNT_W'(1);
                end
            end
            TX_DATA: begin
                if (r_tx_cnt == FULL_LAST) begin
                    w_tx_cnt_n   = '0;
                    w_tx_shift_n = r_tx_shift >> 1;
                    if (r_tx_bit == LAST_BIT) w_tx_state_n = TX_STOP;
                    else                      w_tx_bit_n   = r_tx_bit + BIT_IDX_W'(1);
                end else begin
                    w_tx_cnt_n = r_tx_cnt + CNT_W'(1);
                end
            end
            TX_STOP: begin
                if (r_tx_cnt == FULL_LAST) begin
                    w_tx_cnt_n   = '0;
                    w_tx_state_n = TX_IDLE;
                end else begin
                    w_tx_cnt_n = r_tx_cnt + CNT_W'(1);
                end
            end
            default: w_tx_state_n = TX_IDLE;
        endcase
        // Line level is decoded from the next state so the pin is a clean flop.
        if (w_tx_state_n == TX_START)     w_tx_n = 1'b0;
        else if (w_tx_state_n == TX_DATA) w_tx_n = w_tx_shift_n[0];
        else                              w_tx_n = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_n;
            r_tx_cnt   <= w_tx_cnt_n;
            r_tx_bit   <= w_tx_bit_n;
            r_tx_shift <= w_tx_shift_n;
            r_tx       <= w_tx_n;
        end
    end

    assign tx   = r_tx;
    assign busy = (r_tx_state != TX_IDLE);

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rx        (rx),
        .o_data      (data_out),
        .o_data_ready(data_ready)
`ifdef UART_FRAME_ERR_EN
        ,
        .o_frame_err (frame_err)
`endif
    );
endmodule

// File: tb/tb_uart_top.sv
`timescale 1ns/1ps
// Directed bench for uart_top: reset, TX waveform, RX frames, busy ignore,
// glitch/framing rejection, loopback and mid-frame reset.
module tb_uart_top;
    localparam int CPB    = 434;
    localparam int BIT_NS = CPB * 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_drv;
    logic       loopback;
    logic       rx_in;
    logic       tx;
    logic [7:0] data_in;
    logic       send;
    logic       busy;
    logic [7:0] data_out;
    logic       data_ready;
`ifdef UART_FRAME_ERR_EN
    logic       frame_err;
    int         ferr_cnt = 0;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int rdy_cnt  = 0;
    logic [7:0] exp_q[$];

    assign rx_in = loopback ? tx : rx_drv;

    uart_top dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx_in),
        .tx        (tx),
        .data_in   (data_in),
        .send      (send),
        .busy      (busy),
        .data_out  (data_out),
        .data_ready(data_ready)
`ifdef UART_FRAME_ERR_EN
        ,
        .frame_err (frame_err)
`endif
    );

    // clock / reset block
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // scoreboard: every data_ready cycle must match the next expected byte
    always @(negedge clk) begin
        if (data_ready === 1'b1) begin
            rdy_cnt++;
            check("rx_ready_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) check("rx_data", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
        end
`ifdef UART_FRAME_ERR_EN
        if (frame_err === 1'b1) ferr_cnt++;
`endif
    end

    // driver tasks
    task automatic drive_rx(input logic [7:0] b, input logic stop_bit, input int stop_ns);
        rx_drv = 1'b0;
        #BIT_NS;
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            #BIT_NS;
        end
        rx_drv = stop_bit;
        #stop_ns;
        rx_drv = 1'b1;
    endtask

    // Called at the negedge after an acceptance edge; returns cycles with busy=1.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 6000) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        logic [9:0] frame;
        int         w;
        int         n;
        bit         injected;

        rst = 1'b1; rx_drv = 1'b1; loopback = 1'b0; send = 1'b0; data_in = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_ready", {31'd0, data_ready}, 32'd0);
        check("reset_data_out", {24'd0, data_out}, 32'h00);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // TX 0xA5 with a 0x3C send injected mid-frame, which must be ignored
        frame = 10'b1_1010_0101_0;
        data_in = 8'hA5; send = 1'b1;
        @(posedge clk);
        @(negedge clk);
        send = 1'b0;
        injected = 1'b0;
        for (int k = 0; k < 10; k++) begin
            w = (k == 0) ? CPB / 2 : CPB;
            if (injected) begin
                w = w - 1;
                injected = 1'b0;
            end
            repeat (w) @(posedge clk);
            @(negedge clk);
            check($sformatf("tx_bit%0d", k), {31'd0, tx}, {31'd0, frame[k]});
            if (k == 3) begin
                data_in = 8'h3C; send = 1'b1;
                @(posedge clk);
                @(negedge clk);
                send = 1'b0;
                injected = 1'b1;
            end
        end
        repeat (CPB / 2 - 1) @(posedge clk);
        @(negedge clk);
        check("tx_busy_last_cycle", {31'd0, busy}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("tx_busy_end", {31'd0, busy}, 32'd0);
        check("tx_idle_level", {31'd0, tx}, 32'd1);
        repeat (500) @(negedge clk);
        check("tx_no_second_frame_busy", {31'd0, busy}, 32'd0);
        check("tx_no_second_frame_line", {31'd0, tx}, 32'd1);

        // RX 0xA5
        exp_q.push_back(8'hA5);
        drive_rx(8'hA5, 1'b1, BIT_NS);
        repeat (1000) @(negedge clk);
        check("rx_a5_count", rdy_cnt, 32'd1);
        check("rx_a5_drained", exp_q.size(), 32'd0);
        check("rx_a5_data_out", {24'd0, data_out}, 32'hA5);

        // 100 ns glitch
        rx_drv = 1'b0;
        #100;
        rx_drv = 1'b1;
        repeat (1000) @(negedge clk);
        check("glitch_no_ready", rdy_cnt, 32'd1);

        // 0x5A with a low stop bit
        drive_rx(8'h5A, 1'b0, (BIT_NS * 3) / 4);
        repeat (1000) @(negedge clk);
        check("framing_no_ready", rdy_cnt, 32'd1);
        check("framing_data_hold", {24'd0, data_out}, 32'hA5);
`ifdef UART_FRAME_ERR_EN
        check("framing_err_pulse", ferr_cnt, 32'd1);
`endif

        // loopback, back-to-back frames with send held
        loopback = 1'b1;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h55);
        @(negedge clk);
        data_in = 8'h00; send = 1'b1;
        @(posedge clk);
        @(negedge clk);
        data_in = 8'hFF;
        wait_idle(n);
        check("lb_busy_len0", n, 10 * CPB);
        @(posedge clk);
        @(negedge clk);
        check("lb_back_to_back1", {31'd0, busy}, 32'd1);
        data_in = 8'h55;
        wait_idle(n);
        check("lb_busy_len1", n, 10 * CPB);
        @(posedge clk);
        @(negedge clk);
        send = 1'b0;
        wait_idle(n);
        check("lb_busy_len2", n, 10 * CPB);
        repeat (200) @(negedge clk);
        check("lb_ready_count", rdy_cnt, 32'd4);
        check("lb_drained", exp_q.size(), 32'd0);

        // mid-frame reset while looped back
        data_in = 8'hC3; send = 1'b1;
        @(posedge clk);
        @(negedge clk);
        send = 1'b0;
        repeat (1000) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_tx", {31'd0, tx}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_data_out", {24'd0, data_out}, 32'h00);
        rst = 1'b0;
        repeat (5000) @(negedge clk);
        check("midrst_no_ready", rdy_cnt, 32'd4);
        check("midrst_tx_idle", {31'd0, tx}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
